load_store_unit: RTL

- Data-memory stage directly downstream of the register-file/ALU datapath block.
- Consumes the ALU result as the effective address and source register 2 as store data.
- Runs a multi-cycle req/ack transaction on the data bus, stalling the single-cycle core while it completes.
- Returns aligned, sign/zero-extended load data for register writeback, and flags misaligned, illegal and faulting accesses.

---
 rtl/load_store_unit.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory stage that sits behind the ALU. It takes the ALU result as the
// byte address and rs2 as store data. It runs one req/ack transaction on the
// data bus and holds the core stalled until that transaction finishes. When
// the access retires it returns extended load data, or flags a misaligned,
// illegal, bus-error or timed-out access.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_rd, mem_wr    load / store in execute
//   funct3            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata       effective byte address, store data
//   stall             freeze PC / regfile write while high (combinational)
//   load_data         extended load result, held until the next good load
//   misalign, fault   one-cycle pulses, valid in DONE only
//   fault_cause       01 bus_err, 10 timeout, 11 illegal, 00 otherwise
//   bus_req/we/addr/be/wdata   outbound transaction, stable until ack
//   bus_ack/rdata/err          inbound completion
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misalign,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_BUS  = 2'b01;
   localparam logic [1:0] CAUSE_TMO  = 2'b10;
   localparam logic [1:0] CAUSE_ILL  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              misalign_q, misalign_d;
   logic              fault_q, fault_d;
   logic [1:0]        cause_q, cause_d;

   logic              start;
   logic              illegal;
   logic              misal;
   logic [1:0]        off;
   logic [3:0]        st_be;
   logic [31:0]       st_wdata;
   logic [7:0]        rd_b;
   logic [15:0]       rd_h;
   logic [31:0]       ld_ext;

   assign off   = addr[1:0];
   assign start = (state_q == S_IDLE) && (mem_rd || mem_wr);

   // Access classification. Stores have no unsigned variants, so BU/HU
   // encodings are illegal on a store.
   always_comb begin
      illegal = 1'b0;
      if (mem_rd && mem_wr)
         illegal = 1'b1;
      else if (mem_wr)
         illegal = funct3[2] || (funct3[1:0] == 2'b11);
      else
         illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      misal = ((funct3[1:0] == 2'b01) && off[0]) ||
              ((funct3[1:0] == 2'b10) && (off != 2'b00));
   end

   // Lane steering: enables select the addressed bytes and the data is
   // replicated so every enabled lane sees the right value.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = wdata;
      case (funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << off;
            st_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << off;
            st_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction uses the offset latched at launch, not the live addr.
   // Offset 3 cannot reach the halfword path (filtered as misaligned).
   always_comb begin
      rd_b = bus_rdata[7:0];
      rd_h = bus_rdata[15:0];
      case (off_q)
         2'd1: begin rd_b = bus_rdata[15:8];  rd_h = bus_rdata[23:8];  end
         2'd2: begin rd_b = bus_rdata[23:16]; rd_h = bus_rdata[31:16]; end
         2'd3: begin rd_b = bus_rdata[31:24]; rd_h = bus_rdata[31:16]; end
         default: ;
      endcase
      case (f3_q)
         3'b000:  ld_ext = {{24{rd_b[7]}}, rd_b};
         3'b100:  ld_ext = {24'h0, rd_b};
         3'b001:  ld_ext = {{16{rd_h[15]}}, rd_h};
         3'b101:  ld_ext = {16'h0, rd_h};
         default: ld_ext = bus_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      f3_d        = f3_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
      misalign_d  = 1'b0;
      fault_d     = 1'b0;
      cause_d     = CAUSE_NONE;
      stall       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               stall = 1'b1;
               cnt_d = '0;
               if (illegal) begin
                  state_d = S_DONE;
                  fault_d = 1'b1;
                  cause_d = CAUSE_ILL;
               end else if (misal) begin
                  state_d    = S_DONE;
                  misalign_d = 1'b1;
               end else begin
                  state_d     = S_BUS;
                  bus_req_d   = 1'b1;
                  bus_we_d    = mem_wr;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_be_d    = st_be;
                  bus_wdata_d = st_wdata;
                  f3_d        = funct3;
                  off_d       = off;
               end
            end
         end
         S_BUS: begin
            stall = 1'b1;
            // Ack wins over a coincident timeout.
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = S_DONE;
               if (bus_err) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_BUS;
               end else if (!bus_we_q) begin
                  load_data_d = ld_ext;
               end
            end else if (cnt_q == CNT_LAST) begin
               bus_req_d = 1'b0;
               state_d   = S_DONE;
               fault_d   = 1'b1;
               cause_d   = CAUSE_TMO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // Retire cycle: request inputs are ignored so the still-present
         // instruction is not relaunched.
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         load_data_q <= '0;
         misalign_q  <= 1'b0;
         fault_q     <= 1'b0;
         cause_q     <= CAUSE_NONE;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         misalign_q  <= misalign_d;
         fault_q     <= fault_d;
         cause_q     <= cause_d;
      end
   end

   assign load_data   = load_data_q;
   assign misalign    = misalign_q;
   assign fault       = fault_q;
   assign fault_cause = cause_q;
   assign bus_req     = bus_req_q;
   assign bus_we      = bus_we_q;
   assign bus_addr    = bus_addr_q;
   assign bus_be      = bus_be_q;
   assign bus_wdata   = bus_wdata_q;

endmodule
